sine_lut_arbiter: RTL and testbench

SINE_LUT_ARBITER -- requirements
Module: sine_lut_arbiter

---
 rtl/sine_lut_arbiter.sv | 105 ++++++++++
 tb/tb_sine_lut_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_lut_arbiter.sv
// Shares one sine_lookup among NREQ requesters; tags travel alongside each lookup so responses return in order.
// Build option SINE_ARB_FIXED_PRIO_EN: fixed lowest-index-first arbitration instead of round-robin.
module sine_lut_arbiter #(
   parameter int NREQ    = 4,
   parameter int LUT_LAT = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [11*NREQ-1:0]   req_addr,
   output logic [NREQ-1:0]      req_ready,
   output logic [10:0]          lut_addr,
   input  logic [9:0]           lut_value,
   output logic [NREQ-1:0]      resp_valid,
   output logic [9:0]           resp_data
);

   localparam int IDXW  = $clog2(NREQ);
   localparam int DEPTH = LUT_LAT + 1;

   logic [NREQ-1:0]  r_outstanding;
   logic [IDXW-1:0]  r_last_grant;
   logic [DEPTH-1:0] r_tag_vld;
   logic [IDXW-1:0]  r_tag_idx [DEPTH];
   logic [10:0]      r_lut_addr;
   logic [NREQ-1:0]  r_resp_valid;
   logic [9:0]       r_resp_data;

   logic [NREQ-1:0]  w_eligible;
   logic [NREQ-1:0]  w_grant;
   logic [IDXW-1:0]  w_start;
   logic [IDXW-1:0]  w_scan;
   logic [IDXW-1:0]  w_grant_idx;
   logic             w_found;
   logic [10:0]      w_sel_addr;

   // Gating with rst_n keeps the grant low while reset holds the flags at zero.
   assign w_eligible = req_valid & ~r_outstanding & {NREQ{rst_n}};

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      w_grant     = '0;
      w_grant_idx = '0;
      w_found     = 1'b0;
      w_scan      = '0;
`ifdef SINE_ARB_FIXED_PRIO_EN
      w_start     = '0;
`else
      w_start     = (r_last_grant == IDXW'(NREQ-1)) ? '0 : r_last_grant + 1'b1;
`endif
      for (int k = 0; k < NREQ; k++) begin
         w_scan = IDXW'((int'(w_start) + k) % NREQ);
         if (!w_found && w_eligible[w_scan]) begin
            w_grant[w_scan] = 1'b1;
            w_grant_idx     = w_scan;
            w_found         = 1'b1;
         end
      end
   end

   // Address mux is driven from the grant, keeping req_addr out of the ready path.
   always_comb begin
      w_sel_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) w_sel_addr = req_addr[11*i +: 11];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outstanding <= '0;
         r_last_grant  <= IDXW'(NREQ-1);
         r_tag_vld     <= '0;
         r_lut_addr    <= '0;
         r_resp_valid  <= '0;
         r_resp_data   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples pre-edge values.
         r_outstanding <= (r_outstanding | w_grant) & ~r_resp_valid;
         r_tag_vld     <= {r_tag_vld[DEPTH-2:0], w_found};
         if (w_found) begin
            r_last_grant <= w_grant_idx;
            r_lut_addr   <= w_sel_addr;
         end
         if (r_tag_vld[DEPTH-1]) begin
            r_resp_valid <= NREQ'(1) << r_tag_idx[DEPTH-1];
            r_resp_data  <= lut_value;
         end else begin
            r_resp_valid <= '0;
         end
      end
   end

   // NOTE: the index array is left unreset; it is only read where its matching r_tag_vld bit is set.
   always_ff @(posedge clk) begin
      r_tag_idx[0] <= w_grant_idx;
      for (int s = 1; s < DEPTH; s++) r_tag_idx[s] <= r_tag_idx[s-1];
   end

   assign req_ready  = w_grant;
   assign lut_addr   = r_lut_addr;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_sine_lut_arbiter.sv
// Bench for sine_lut_arbiter: directed scenarios plus random traffic against a transaction-level model
// that predicts grants by arbitration rule and responses as addr^0x155 five cycles after acceptance.
module tb_sine_lut_arbiter;

   localparam int NREQ = 4;
   localparam int MAXC = 4096;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [11*NREQ-1:0] req_addr;
   logic [NREQ-1:0]   req_ready;
   logic [10:0]       lut_addr;
   logic [9:0]        lut_value = '0;
   logic [NREQ-1:0]   resp_valid;
   logic [9:0]        resp_data;

   logic [9:0] r_lut_d1 = '0;
   logic [9:0] r_lut_d2 = '0;

   sine_lut_arbiter #(.NREQ(NREQ), .LUT_LAT(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .lut_addr   (lut_addr),
      .lut_value  (lut_value),
      .resp_valid (resp_valid),
      .resp_data  (resp_data)
   );

   always #5 clk = ~clk;

   // Behavioural 3-cycle sine_lookup stand-in.
   always @(posedge clk) begin
      r_lut_d1  <= lut_addr[9:0] ^ 10'h155;
      r_lut_d2  <= r_lut_d1;
      lut_value <= r_lut_d2;
   end

   typedef struct {
      int         due;
      int         idx;
      logic [9:0] data;
   } resp_t;

   resp_t       pend[$];
   logic [3:0]  m_out;
   int          m_last;
   logic [10:0] m_lut_addr;
   logic [9:0]  m_resp_data;

   int cyc;
   int n_checks;
   int n_pass;
   int n_fail;

   logic [3:0]  obs_rdy [MAXC];
   logic [3:0]  obs_rv  [MAXC];
   logic [9:0]  obs_rd  [MAXC];
   logic [10:0] obs_la  [MAXC];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   task automatic record();
      if (cyc < MAXC) begin
         obs_rdy[cyc] = req_ready;
         obs_rv[cyc]  = resp_valid;
         obs_rd[cyc]  = resp_data;
         obs_la[cyc]  = lut_addr;
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '1;
      pend.delete();
      m_out       = '0;
      m_last      = NREQ - 1;
      m_lut_addr  = '0;
      m_resp_data = '0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         record();
         check("rst_ready", req_ready, 0);
         check("rst_resp_valid", resp_valid, 0);
         check("rst_resp_data", resp_data, 0);
         check("rst_lut_addr", lut_addr, 0);
         @(posedge clk);
         #1;
         cyc++;
      end
      rst_n     = 1'b1;
      req_valid = '0;
   endtask

   // One clock of model-checked operation using the inputs currently driven.
   task automatic step();
      logic [3:0] exp_rv;
      logic [3:0] exp_rdy;
      resp_t      e;
      int         g;
      int         i;
      @(negedge clk);
      record();
      exp_rv = '0;
      while (pend.size() > 0 && pend[0].due <= cyc) begin
         e = pend.pop_front();
         exp_rv[e.idx] = 1'b1;
         m_resp_data   = e.data;
      end
      check("resp_valid", resp_valid, exp_rv);
      check("resp_data", resp_data, m_resp_data);
      check("lut_addr", lut_addr, m_lut_addr);
      g = -1;
`ifdef SINE_ARB_FIXED_PRIO_EN
      for (int k = 0; k < NREQ; k++) begin
         if (g < 0 && req_valid[k] && !m_out[k]) g = k;
      end
`else
      for (int k = 1; k <= NREQ; k++) begin
         i = (m_last + k) % NREQ;
         if (g < 0 && req_valid[i] && !m_out[i]) g = i;
      end
`endif
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      if (g >= 0) begin
         m_out[g]   = 1'b1;
         m_last     = g;
         m_lut_addr = req_addr[g*11 +: 11];
         pend.push_back('{cyc + 5, g, m_lut_addr[9:0] ^ 10'h155});
      end
      m_out = m_out & ~exp_rv;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      int c0;
      int g0;
      int nbad;
      int nacc;
      int nrsp;
      rst_n     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      cyc       = 0;
      n_checks  = 0;
      n_pass    = 0;
      n_fail    = 0;

      // Single request, then idle hold.
      do_reset();
      req_addr[10:0] = 11'h010;
      req_valid      = 4'b0001;
      c0 = cyc;
      repeat (6) step();
      req_valid = '0;
      repeat (10) step();
      check("single_grant", obs_rdy[c0], 4'b0001);
      for (int k = 1; k <= 5; k++) check("single_ready_low", obs_rdy[c0+k][0], 0);
      check("single_lut_addr", obs_la[c0+1], 11'h010);
      check("single_no_early_resp", obs_rv[c0+4], 0);
      check("single_resp_valid", obs_rv[c0+5], 4'b0001);
      check("single_resp_data", obs_rd[c0+5], 10'h145);
      nbad = 0;
      for (int k = 6; k <= 15; k++) begin
         if (obs_la[c0+k] !== 11'h010 || obs_rd[c0+k] !== 10'h145 || obs_rv[c0+k] !== 4'b0000) nbad++;
      end
      check("idle_hold", nbad, 0);

      // All four requesting continuously from reset.
      do_reset();
      for (int r = 0; r < NREQ; r++) req_addr[r*11 +: 11] = 11'($urandom);
      req_valid = 4'b1111;
      c0 = cyc;
      repeat (20) step();
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         check("all4_grant_order", obs_rdy[c0+k], 4'b0001 << k);
         check("all4_resp_order", obs_rv[c0+5+k], 4'b0001 << k);
      end
      check("all4_gap", obs_rdy[c0+4], 0);
      check("all4_no_regrant_at_resp", obs_rdy[c0+5], 0);
      check("all4_regrant0", obs_rdy[c0+6], 4'b0001);
      repeat (8) step();

      // Requesters 1 and 3 with last_grant = 1.
      do_reset();
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      repeat (7) step();
      req_valid = 4'b1010;
      c0 = cyc;
      repeat (2) step();
      req_valid = '0;
      repeat (8) step();
`ifdef SINE_ARB_FIXED_PRIO_EN
      check("prio_first", obs_rdy[c0], 4'b0010);
      check("prio_second", obs_rdy[c0+1], 4'b1000);
`else
      check("rr_first", obs_rdy[c0], 4'b1000);
      check("rr_second", obs_rdy[c0+1], 4'b0010);
`endif

      // Reset pulsed two cycles after accepting requester 2.
      do_reset();
      req_valid = 4'b0100;
      c0 = cyc;
      step();
      req_valid = '0;
      step();
      do_reset();
      req_valid = 4'b0101;
      g0 = cyc;
      step();
      req_valid = '0;
      repeat (10) step();
      check("rst_mid_accept2", obs_rdy[c0], 4'b0100);
      check("rst_mid_first0", obs_rdy[g0], 4'b0001);
      nbad = 0;
      for (int k = c0; k <= g0 + 10; k++) if (obs_rv[k][2]) nbad++;
      check("rst_mid_no_resp2", nbad, 0);
      check("rst_mid_resp0", obs_rv[g0+5], 4'b0001);

      // Requester 0 holds valid while outstanding.
      do_reset();
      req_addr[10:0] = 11'h3a7;
      req_valid      = 4'b0001;
      c0 = cyc;
      repeat (24) step();
      req_valid = '0;
      repeat (6) step();
      nacc = 0;
      nrsp = 0;
      for (int k = c0; k < c0 + 24; k++) begin
         if (obs_rdy[k][0]) nacc++;
         if (obs_rv[k][0]) nrsp++;
      end
      check("hold_accepts", nacc, 4);
      check("hold_resps", nrsp, 4);
      check("hold_not_at_5", obs_rdy[c0+5], 0);
      check("hold_at_6", obs_rdy[c0+6], 4'b0001);

      // Random traffic with occasional resets.
      do_reset();
      for (int n = 0; n < 500; n++) begin
         req_valid = 4'($urandom_range(0, 15));
         for (int r = 0; r < NREQ; r++) req_addr[r*11 +: 11] = 11'($urandom);
         if ($urandom_range(0, 99) == 0) do_reset();
         else step();
      end
      req_valid = '0;
      repeat (8) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
